cnn_layer_accel_row_fetcher: RTL and testbench
==============================================

CNN_LAYER_ACCEL_ROW_FETCHER -- requirements
Module: cnn_layer_accel_row_fetcher

Interface
REQ-001 SHALL have parameters (name, default, meaning): C_PIXEL_WIDTH, 16, bits per channel pixel; C_NUM_CHANNELS, 8, channels per beat; C_ROW_W, 10, row-count width; C_COL_W, 10, col-count width; C_ADDR_W, 20, source word address width; C_FIFO_DEPTH, 4, pixel buffer entries (power of 2, >=2).
REQ-002 SHALL use one clock and an asynchronous active-low reset, as listed below.
REQ-003 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  descriptor accepted when both high
- cfg_num_rows  in  C_ROW_W  rows minus one
- cfg_num_cols  in  C_COL_W  cols minus one
- cfg_base_addr  in  C_ADDR_W  first word address
- job_fetch_request  in  1  accelerator requests one row
- job_fetch_ack  out  1  one-cycle ack of request
- job_fetch_complete  out  1  one-cycle pulse after last beat of row
- rd_addr_valid  out  1  source read request
- rd_addr_ready  in  1  source accepts address
- rd_addr  out  C_ADDR_W  word address
- rd_data_valid  in  1  read return, no backpressure, in order
- rd_data  in  C_PIXEL_WIDTH*C_NUM_CHANNELS  channel 0 in LSBs
- pixel_valid  out  1  beat valid
- pixel_ready  in  1  beat accepted when both high
- pixel_data  out  C_PIXEL_WIDTH*C_NUM_CHANNELS  beat to accelerator
- job_done  out  1  one-cycle pulse after final row complete

Function
REQ-004 SHALL implement FSM IDLE -> ARMED -> ACK -> STREAM -> ROW_END -> (ARMED | DONE) -> IDLE.
REQ-005 IDLE: cfg_ready=1; on cfg_valid latch rows, cols, base; row_cnt=0, addr=base; go ARMED.
REQ-006 ARMED: wait for job_fetch_request high; go ACK.
REQ-007 ACK: job_fetch_ack=1 for exactly one cycle; go STREAM.
REQ-008 STREAM: issue exactly num_cols+1 addresses, incrementing addr by 1 per accepted address; forward exactly num_cols+1 beats; go ROW_END when last beat handshakes on pixel side.
REQ-009 Addresses SHALL be issued only while credits>0; credits = C_FIFO_DEPTH - (FIFO occupancy + outstanding reads); count updated same cycle for simultaneous issue/return/pop.
REQ-010 Return data SHALL be written into a FIFO; pixel_valid = FIFO not empty; pixel_data = FIFO head; pop on pixel_valid&pixel_ready; no beat dropped or duplicated.
REQ-011 ROW_END: job_fetch_complete=1 for one cycle; if row_cnt==num_rows go DONE else row_cnt+1, go ARMED. Address continues from previous row (row-major contiguous).
REQ-012 DONE: job_done=1 for one cycle; go IDLE.
REQ-013 rd_addr_valid SHALL stay high with stable rd_addr until rd_addr_ready.
REQ-014 job_fetch_request outside ARMED SHALL be ignored; cfg_valid outside IDLE SHALL not be accepted.
REQ-015 Address wraps modulo 2^C_ADDR_W without error.
REQ-016 Minimum one-row latency: ACK to first pixel_valid = 1 + source latency cycles.

Reset
REQ-017 On rst_n low, asynchronously: state IDLE, FIFO empty, credits=C_FIFO_DEPTH, counters 0; outputs cfg_ready=1 (after reset only), job_fetch_ack=0, job_fetch_complete=0, rd_addr_valid=0, rd_addr=0, pixel_valid=0, pixel_data=0, job_done=0.
REQ-018 Reset mid-row SHALL discard FIFO contents; read returns arriving while rst_n low SHALL be ignored.

Structure
REQ-019 FSM state enum and width helpers SHALL live in shared package cnn_layer_accel_pkg.
REQ-020 Pixel buffer SHALL be sub-module cnn_layer_accel_sync_fifo (params width, depth; flags full/empty/count).

Verification
REQ-021 rows=1(cfg 0), cols=4(cfg 3), base=0x100, zero-latency source, pixel_ready=1 -> addresses 0x100..0x103, 4 beats, one complete pulse, job_done one cycle later.
REQ-022 rows=10, cols=10, base=0 -> 10 ack/complete pairs, 100 beats, addresses 0..99 in order, data matches source.
REQ-023 pixel_ready toggling 1/0, source latency 3 -> outstanding+occupancy never exceeds 4, no lost beats.
REQ-024 base=0xFFFFE, cols=4 -> addresses 0xFFFFE,0xFFFFF,0x00000,0x00001.
REQ-025 rst_n low after 5 beats of row 2 -> all outputs reset values same cycle; new job afterwards streams from its own base.
REQ-026 job_fetch_request held high through STREAM -> no second ack until next ARMED.

Source files
------------

// File: rtl/cnn_layer_accel_pkg.sv
// Shared types for the CNN layer accelerator row fetcher: FSM state encoding
// and counter width helper for the pixel buffer.
package cnn_layer_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACK,
        ST_STREAM,
        ST_ROW_END,
        ST_DONE
    } fetch_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_sync_fifo.sv
// Single-clock FIFO used as the pixel buffer; caller guarantees no write when
// full and no read when empty.
module cnn_layer_accel_sync_fifo
    import cnn_layer_accel_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [cnt_width(DEPTH)-1:0]    count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/cnn_layer_accel_row_fetcher.sv
// Fetches one image row per accelerator request from a word-addressed source,
// buffering returned beats under a credit scheme so the FIFO never overflows.
module cnn_layer_accel_row_fetcher
    import cnn_layer_accel_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH  = 16,
    parameter int unsigned C_NUM_CHANNELS = 8,
    parameter int unsigned C_ROW_W        = 10,
    parameter int unsigned C_COL_W        = 10,
    parameter int unsigned C_ADDR_W       = 20,
    parameter int unsigned C_FIFO_DEPTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [C_ROW_W-1:0]                      cfg_num_rows,
    input  logic [C_COL_W-1:0]                      cfg_num_cols,
    input  logic [C_ADDR_W-1:0]                     cfg_base_addr,
    input  logic                                    job_fetch_request,
    output logic                                    job_fetch_ack,
    output logic                                    job_fetch_complete,
    output logic                                    rd_addr_valid,
    input  logic                                    rd_addr_ready,
    output logic [C_ADDR_W-1:0]                     rd_addr,
    input  logic                                    rd_data_valid,
    input  logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] rd_data,
    output logic                                    pixel_valid,
    input  logic                                    pixel_ready,
    output logic [C_PIXEL_WIDTH*C_NUM_CHANNELS-1:0] pixel_data,
    output logic                                    job_done
);
    localparam int unsigned DW    = C_PIXEL_WIDTH * C_NUM_CHANNELS;
    localparam int unsigned CNT_W = cnt_width(C_FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [C_ROW_W-1:0]    rows_q, rows_d, row_cnt_q, row_cnt_d;
    logic [C_COL_W-1:0]    cols_q, cols_d;
    logic [C_ADDR_W-1:0]   addr_q, addr_d;
    logic [C_COL_W:0]      issued_q, issued_d, beats_q, beats_d;
    logic [CNT_W-1:0]      outst_q, outst_d;

    logic [CNT_W-1:0]      fifo_count, used;
    logic                  fifo_full, fifo_empty, fifo_wr;
    logic [DW-1:0]         fifo_head;
    logic                  addr_fire, data_ret, pix_fire, last_beat;

    // Credits: a slot is reserved per outstanding read, so returns always fit.
    assign used          = fifo_count + outst_q;
    assign rd_addr_valid = (state_q == ST_STREAM) && (issued_q <= {1'b0, cols_q})
                           && (used < CNT_W'(C_FIFO_DEPTH));
    assign rd_addr       = addr_q;
    assign addr_fire     = rd_addr_valid && rd_addr_ready;
    // Same-cycle returns are allowed for a zero-latency source.
    assign data_ret      = rd_data_valid && ((outst_q != '0) || addr_fire);
    assign fifo_wr       = data_ret && !fifo_full;
    assign outst_d       = outst_q + CNT_W'(addr_fire) - CNT_W'(data_ret);

    assign pixel_valid   = !fifo_empty;
    assign pixel_data    = fifo_empty ? '0 : fifo_head;
    assign pix_fire      = pixel_valid && pixel_ready;
    assign last_beat     = pix_fire && (beats_q == {1'b0, cols_q});

    cnn_layer_accel_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (C_FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i (rd_data),
        .rd_en_i   (pix_fire),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt_q <= '0;
            addr_q    <= '0;
            issued_q  <= '0;
            beats_q   <= '0;
            outst_q   <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_cnt_q <= row_cnt_d;
            addr_q    <= addr_d;
            issued_q  <= issued_d;
            beats_q   <= beats_d;
            outst_q   <= outst_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        rows_d             = rows_q;
        cols_d             = cols_q;
        row_cnt_d          = row_cnt_q;
        addr_d             = addr_q;
        issued_d           = issued_q;
        beats_d            = beats_q;
        cfg_ready          = 1'b0;
        job_fetch_ack      = 1'b0;
        job_fetch_complete = 1'b0;
        job_done           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    rows_d    = cfg_num_rows;
                    cols_d    = cfg_num_cols;
                    addr_d    = cfg_base_addr;
                    row_cnt_d = '0;
                    state_d   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (job_fetch_request) state_d = ST_ACK;
            end
            ST_ACK: begin
                job_fetch_ack = 1'b1;
                issued_d      = '0;
                beats_d       = '0;
                state_d       = ST_STREAM;
            end
            ST_STREAM: begin
                if (addr_fire) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                end
                if (pix_fire) beats_d = beats_q + 1'b1;
                if (last_beat) state_d = ST_ROW_END;
            end
            ST_ROW_END: begin
                job_fetch_complete = 1'b1;
                if (row_cnt_q == rows_q) begin
                    state_d = ST_DONE;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = ST_ARMED;
                end
            end
            ST_DONE: begin
                job_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cnn_layer_accel_row_fetcher.sv
// Randomized bench: a latency-configurable source model feeds the fetcher and
// every address and beat is compared against base+index arithmetic.
module tb_cnn_layer_accel_row_fetcher;
    localparam int unsigned PW = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned RW = 10;
    localparam int unsigned CW = 10;
    localparam int unsigned AW = 20;
    localparam int unsigned FD = 4;
    localparam int unsigned DW = PW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid, cfg_ready;
    logic [RW-1:0] cfg_num_rows;
    logic [CW-1:0] cfg_num_cols;
    logic [AW-1:0] cfg_base_addr;
    logic          job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic          rd_addr_valid, rd_addr_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          pixel_valid, pixel_ready;
    logic [DW-1:0] pixel_data;
    logic          job_done;

    always #5 clk = ~clk;

    cnn_layer_accel_row_fetcher #(
        .C_PIXEL_WIDTH  (PW),
        .C_NUM_CHANNELS (NC),
        .C_ROW_W        (RW),
        .C_COL_W        (CW),
        .C_ADDR_W       (AW),
        .C_FIFO_DEPTH   (FD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_num_rows       (cfg_num_rows),
        .cfg_num_cols       (cfg_num_cols),
        .cfg_base_addr      (cfg_base_addr),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .rd_addr_valid      (rd_addr_valid),
        .rd_addr_ready      (rd_addr_ready),
        .rd_addr            (rd_addr),
        .rd_data_valid      (rd_data_valid),
        .rd_data            (rd_data),
        .pixel_valid        (pixel_valid),
        .pixel_ready        (pixel_ready),
        .pixel_data         (pixel_data),
        .job_done           (job_done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int ch = 0; ch < NC; ch++)
            d[ch*PW +: PW] = PW'(a) ^ PW'(ch * 32'h1357) ^ PW'(a >> 4);
        return d;
    endfunction

    typedef struct {
        logic [AW-1:0] a;
        int unsigned   due;
    } rd_t;
    rd_t srcq[$];

    // Job model and scoreboard state
    logic [AW-1:0] exp_base;
    int unsigned   lat = 1, pr_mode = 0, ar_rand = 0, hold_req = 0, req_en = 0;
    int unsigned   cyc = 0, n_addr, n_beats, n_ack, n_cmp, n_done;
    int unsigned   last_cmp_cyc, done_cyc, bad_cfg;
    int            max_infl;
    logic          active = 1'b0;

    // Driver: source returns, backpressure and request patterns
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            srcq.delete();
        end else if (srcq.size() > 0 && srcq[0].due <= cyc) begin
            rd_data_valid = 1'b1;
            rd_data       = data_of(srcq[0].a);
            void'(srcq.pop_front());
        end else begin
            rd_data_valid = 1'b0;
            rd_data       = '0;
        end
        rd_addr_ready     = (ar_rand != 0) ? ($urandom_range(3) != 0) : 1'b1;
        pixel_ready       = (pr_mode == 0) ? 1'b1 :
                            (pr_mode == 1) ? ~pixel_ready : 1'($urandom_range(1));
        job_fetch_request = (req_en != 0) && ((hold_req != 0) || ($urandom_range(2) == 0));
    end

    // Monitor: sampled mid-cycle, each handshake completes at the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_addr_valid && rd_addr_ready) begin
                check("rd_addr", DW'(rd_addr), DW'(AW'(exp_base + AW'(n_addr))));
                srcq.push_back('{a: rd_addr, due: cyc + lat});
                n_addr++;
            end
            if (pixel_valid && pixel_ready) begin
                check("pixel_data", pixel_data, data_of(AW'(exp_base + AW'(n_beats))));
                n_beats++;
            end
            if (job_fetch_ack) n_ack++;
            if (job_fetch_complete) begin
                n_cmp++;
                last_cmp_cyc = cyc;
            end
            if (job_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (int'(n_addr) - int'(n_beats) > max_infl) max_infl = int'(n_addr) - int'(n_beats);
            if (active && cfg_ready) bad_cfg++;
            if (cfg_valid && cfg_ready) active = 1'b1;
            if (job_done) active = 1'b0;
        end
    end

    task automatic start_job(input logic [AW-1:0] base, input int unsigned rows_m1,
                             input int unsigned cols_m1, input int unsigned lat_i,
                             input int unsigned prm, input int unsigned arr, input int unsigned hold);
        int unsigned t;
        exp_base = base; lat = lat_i; pr_mode = prm; ar_rand = arr; hold_req = hold;
        n_addr = 0; n_beats = 0; n_ack = 0; n_cmp = 0; n_done = 0;
        max_infl = 0; bad_cfg = 0; last_cmp_cyc = 0; done_cyc = 0;
        @(posedge clk); #2;
        cfg_valid = 1'b1; cfg_num_rows = RW'(rows_m1); cfg_num_cols = CW'(cols_m1); cfg_base_addr = base;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cfg_ready && t < 50);
        check("cfg_accept", DW'(cfg_ready), DW'(1));
        @(posedge clk); #2;
        cfg_valid = 1'b0;
        cfg_num_rows = '0; cfg_num_cols = '0; cfg_base_addr = '0;
        req_en = 1;
    endtask

    task automatic finish_job(input int unsigned rows_m1, input int unsigned cols_m1);
        int unsigned t = 0;
        int unsigned beats = (rows_m1 + 1) * (cols_m1 + 1);
        while (n_done == 0 && t < 20000) begin
            @(negedge clk); #2;
            t++;
        end
        req_en = 0;
        repeat (3) @(negedge clk);
        #2;
        check("job_done_pulses", DW'(n_done), DW'(1));
        check("ack_count", DW'(n_ack), DW'(rows_m1 + 1));
        check("complete_count", DW'(n_cmp), DW'(rows_m1 + 1));
        check("addr_count", DW'(n_addr), DW'(beats));
        check("beat_count", DW'(n_beats), DW'(beats));
        check("done_after_complete", DW'(done_cyc - last_cmp_cyc), DW'(1));
        check("inflight_within_depth", DW'(max_infl <= int'(FD)), DW'(1));
        check("cfg_blocked_when_busy", DW'(bad_cfg), DW'(0));
        check("cfg_ready_idle", DW'(cfg_ready), DW'(1));
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int unsigned rows_m1,
                           input int unsigned cols_m1, input int unsigned lat_i,
                           input int unsigned prm, input int unsigned arr, input int unsigned hold);
        start_job(base, rows_m1, cols_m1, lat_i, prm, arr, hold);
        finish_job(rows_m1, cols_m1);
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_cfg_ready"}, DW'(cfg_ready), DW'(1));
        check({where, "_ack"}, DW'(job_fetch_ack), DW'(0));
        check({where, "_complete"}, DW'(job_fetch_complete), DW'(0));
        check({where, "_rd_addr_valid"}, DW'(rd_addr_valid), DW'(0));
        check({where, "_rd_addr"}, DW'(rd_addr), DW'(0));
        check({where, "_pixel_valid"}, DW'(pixel_valid), DW'(0));
        check({where, "_pixel_data"}, pixel_data, DW'(0));
        check({where, "_job_done"}, DW'(job_done), DW'(0));
    endtask

    initial begin
        int unsigned t;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_num_rows = '0; cfg_num_cols = '0; cfg_base_addr = '0;
        job_fetch_request = 1'b0; rd_addr_ready = 1'b1; rd_data_valid = 1'b0; rd_data = '0;
        pixel_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        run_job(AW'('h100), 0, 3, 1, 0, 0, 0);       // single 4-wide row
        run_job(AW'(0), 9, 9, 1, 0, 0, 0);           // 10x10 image
        run_job(AW'('h3000), 2, 7, 3, 1, 0, 0);      // toggling ready, latency 3
        run_job(AW'('hFFFFE), 0, 3, 2, 0, 0, 0);     // address wrap
        run_job(AW'('h4440), 3, 5, 2, 2, 1, 1);      // request held high throughout
        for (int j = 0; j < 3; j++)
            run_job(AW'($urandom), $urandom_range(4), $urandom_range(12),
                    $urandom_range(4, 1), $urandom_range(2), 1, $urandom_range(1));

        // Reset in the middle of the second row
        start_job(AW'('h2000), 3, 8, 2, 0, 0, 0);
        t = 0;
        while (n_beats < 9 + 5 && t < 2000) begin
            @(negedge clk); #2;
            t++;
        end
        check("reached_row2_beat5", DW'(n_beats >= 14), DW'(1));
        req_en = 0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrow");
        rd_data_valid = 1'b1;
        rd_data = {4{32'hDEAD_BEEF}};
        repeat (3) @(posedge clk);
        #3;
        rd_data_valid = 1'b0;
        rd_data = '0;
        rst_n = 1'b1;
        active = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_pixel_valid", DW'(pixel_valid), DW'(0));
        check("post_reset_rd_addr_valid", DW'(rd_addr_valid), DW'(0));
        run_job(AW'('h5550), 1, 6, 1, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
